// File: rtl/avm_audio_config_master.sv
// Avalon-MM master that writes the WM8731 codec bring-up table through the audio
// controller's I2C command register, polling the status register after each write.
module avm_audio_config_master #(
  parameter int unsigned SYSCLK      = 50,
  parameter logic [4:0]  I2C_ADDR    = 5'h00,
  parameter logic [4:0]  STATUS_ADDR = 5'h1F,
  parameter int unsigned BUSY_BIT    = 0,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned POLL_GAP    = 16,
  parameter int unsigned TIMEOUT_CYC = SYSCLK * 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  entry_idx,
  output logic [4:0]  avm_address,
  output logic        avm_select,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  localparam int unsigned NUM_ENTRIES = 11;
  localparam int unsigned LAST_IDX    = NUM_ENTRIES - 1;
  localparam int unsigned GW          = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned LW          = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [4:0]  BB          = 5'(BUSY_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_RD,
    S_RDWAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t         state, state_next;
  logic [GW-1:0]  gcnt, gcnt_next;
  logic [LW-1:0]  lcnt, lcnt_next;
  logic [TW-1:0]  tcnt, tcnt_next, tcnt_inc;
  logic           timeout;
  logic           busy_next, done_next, error_next;
  logic [3:0]     idx_next;
  logic [4:0]     addr_next;
  logic           sel_next, rd_next, wr_next;
  logic [31:0]    wdata_next;

  // Codec command words: {reg[6:0], data[8:0]}
  function automatic logic [15:0] cmd_word(input logic [3:0] idx);
    case (idx)
      4'd0:    cmd_word = 16'h1E00;
      4'd1:    cmd_word = 16'h0017;
      4'd2:    cmd_word = 16'h0217;
      4'd3:    cmd_word = 16'h0479;
      4'd4:    cmd_word = 16'h0679;
      4'd5:    cmd_word = 16'h0812;
      4'd6:    cmd_word = 16'h0A00;
      4'd7:    cmd_word = 16'h0C00;
      4'd8:    cmd_word = 16'h0E02;
      4'd9:    cmd_word = 16'h1000;
      4'd10:   cmd_word = 16'h1201;
      default: cmd_word = 16'h0000;
    endcase
  endfunction

  assign tcnt_inc = tcnt + TW'(1);
  // Counter reaches TIMEOUT_CYC at the edge this is seen
  assign timeout  = (tcnt_inc == TW'(TIMEOUT_CYC));

  // Next-state and next-output logic
  always_comb begin
    state_next = state;
    idx_next   = entry_idx;
    done_next  = done;
    error_next = error;
    gcnt_next  = gcnt;
    lcnt_next  = lcnt;
    tcnt_next  = '0;
    busy_next  = 1'b0;
    sel_next   = 1'b0;
    rd_next    = 1'b0;
    wr_next    = 1'b0;
    addr_next  = '0;
    wdata_next = '0;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next = S_WRITE;
          idx_next   = '0;
          done_next  = 1'b0;
          error_next = 1'b0;
        end
      end
      S_WRITE: begin
        tcnt_next  = tcnt_inc;
        gcnt_next  = '0;
        state_next = S_GAP;
      end
      S_GAP: begin
        tcnt_next = tcnt_inc;
        if (timeout) begin
          state_next = S_ERROR;
          error_next = 1'b1;
        end else if (gcnt == GW'(POLL_GAP - 1)) begin
          state_next = S_RD;
        end else begin
          gcnt_next = gcnt + GW'(1);
        end
      end
      S_RD: begin
        tcnt_next = tcnt_inc;
        lcnt_next = '0;
        if (timeout) begin
          state_next = S_ERROR;
          error_next = 1'b1;
        end else begin
          state_next = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        tcnt_next = tcnt_inc;
        // A not-busy sample beats a timeout landing on the same cycle
        if (lcnt == LW'(RD_LATENCY - 1) && !avm_readdata[BB]) begin
          if (entry_idx == 4'(LAST_IDX)) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = S_WRITE;
            idx_next   = entry_idx + 4'd1;
          end
        end else if (timeout) begin
          state_next = S_ERROR;
          error_next = 1'b1;
        end else if (lcnt == LW'(RD_LATENCY - 1)) begin
          state_next = S_GAP;
          gcnt_next  = '0;
        end else begin
          lcnt_next = lcnt + LW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (state_next == S_WRITE) begin
      tcnt_next = '0;
    end

    case (state_next)
      S_WRITE: begin
        busy_next  = 1'b1;
        sel_next   = 1'b1;
        wr_next    = 1'b1;
        addr_next  = I2C_ADDR;
        wdata_next = {16'h0000, cmd_word(idx_next)};
      end
      S_RD: begin
        busy_next = 1'b1;
        sel_next  = 1'b1;
        rd_next   = 1'b1;
        addr_next = STATUS_ADDR;
      end
      S_GAP, S_RDWAIT: busy_next = 1'b1;
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      gcnt          <= '0;
      lcnt          <= '0;
      tcnt          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      entry_idx     <= '0;
      avm_address   <= '0;
      avm_select    <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
    end else begin
      state         <= state_next;
      gcnt          <= gcnt_next;
      lcnt          <= lcnt_next;
      tcnt          <= tcnt_next;
      busy          <= busy_next;
      done          <= done_next;
      error         <= error_next;
      entry_idx     <= idx_next;
      avm_address   <= addr_next;
      avm_select    <= sel_next;
      avm_read      <= rd_next;
      avm_write     <= wr_next;
      avm_writedata <= wdata_next;
    end
  end

endmodule

// File: tb/tb_avm_audio_config_master.sv
// Bench for avm_audio_config_master: randomized status slave plus a schedule-based
// model of when every strobe and flag must appear.
module tb_avm_audio_config_master;

  localparam int unsigned P      = 4;
  localparam int unsigned L      = 3;
  localparam int unsigned T      = 500;
  localparam int unsigned MW     = 2048;
  localparam int unsigned NOHANG = 99;
  localparam int unsigned WLOG   = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [3:0]  entry_idx;
  logic [4:0]  avm_address;
  logic        avm_select, avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;

  avm_audio_config_master #(
    .SYSCLK(50), .I2C_ADDR(5'h00), .STATUS_ADDR(5'h1F), .BUSY_BIT(0),
    .RD_LATENCY(L), .POLL_GAP(P), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .entry_idx(entry_idx), .avm_address(avm_address), .avm_select(avm_select),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [15:0] tbl [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                            16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Status slave: busy for sdly cycles after each write (forever on entry shang)
  int unsigned sdly = 40, shang = NOHANG, seq_w0 = 0, tot_w = 0;
  int unsigned wcyc [WLOG];
  logic [31:0] wdat [WLOG];
  int unsigned cur_b = 0, pend_cyc = 0;
  bit          pend = 0, pend_val = 0;

  always @(negedge clk) begin
    logic [31:0] rnd;
    rnd = $urandom;
    if (!rst) begin
      pend = 0;
    end else begin
      if (avm_write) begin
        if (tot_w < WLOG) begin
          wcyc[tot_w] = cyc;
          wdat[tot_w] = avm_writedata;
        end
        tot_w++;
        cur_b = (tot_w - 1 - seq_w0 == shang) ? 32'hFFFF_FFF0 : cyc + sdly;
      end
      if (avm_read) begin
        pend     = 1;
        pend_cyc = cyc + L;
        pend_val = (cyc < cur_b);
      end
    end
    // Busy bit is inverted on every cycle except the one the read data is valid
    if (pend && cyc == pend_cyc) begin
      rnd[0] = pend_val;
      pend   = 0;
    end else if (pend) begin
      rnd[0] = ~pend_val;
    end
    avm_readdata = rnd;
  end

  // Model: per-cycle expected strobes and index from the write/poll schedule
  bit          e_wr [MW];
  bit          e_rd [MW];
  logic [31:0] e_wd [MW];
  int unsigned e_idx [MW];
  int unsigned mbase = 1, mend = 0, f_idx = 0;
  bit          f_done = 0, f_err = 0;

  task automatic build_model(input int unsigned base, input int unsigned dly,
                             input int unsigned hang);
    int unsigned w, r, nxt;
    bit ok;
    for (int i = 0; i < MW; i++) begin
      e_wr[i] = 0; e_rd[i] = 0; e_wd[i] = '0; e_idx[i] = 0;
    end
    mbase = base; mend = 0; f_done = 0; f_err = 0; f_idx = 0;
    w = 0;
    for (int unsigned k = 0; k < 11; k++) begin
      e_wr[w] = 1;
      e_wd[w] = {16'h0000, tbl[k]};
      ok = 0; nxt = 0;
      for (int unsigned j = 0; j < 1000; j++) begin
        r = w + 1 + P + j * (P + 1 + L);
        if (r > w + T - 1) break;
        e_rd[r] = 1;
        if (k != hang && r >= w + dly && r + L <= w + T - 1) begin
          ok = 1; nxt = r + L + 1;
          break;
        end
      end
      if (!ok) begin
        for (int unsigned c = w; c < w + T; c++) e_idx[c] = k;
        mend = w + T; f_err = 1; f_idx = k;
        return;
      end
      for (int unsigned c = w; c < nxt; c++) e_idx[c] = k;
      w = nxt;
    end
    mend = w; f_done = 1; f_idx = 10;
  endtask

  always @(negedge clk) begin
    int unsigned rel, xi;
    bit xw, xr, xb, xd, xe;
    logic [31:0] xwd;
    logic [4:0] xa;
    if (cyc >= mbase) begin
      rel = cyc - mbase;
      if (rel < mend) begin
        xw = e_wr[rel]; xr = e_rd[rel]; xwd = e_wd[rel];
        xb = 1; xd = 0; xe = 0; xi = e_idx[rel];
      end else begin
        xw = 0; xr = 0; xwd = '0;
        xb = 0; xd = f_done; xe = f_err; xi = f_idx;
      end
      if (!xw) xwd = '0;
      xa = xw ? 5'h00 : (xr ? 5'h1F : 5'h00);
      chk("avm_write", 32'(avm_write), 32'(xw));
      chk("avm_read", 32'(avm_read), 32'(xr));
      chk("avm_select", 32'(avm_select), 32'(xw | xr));
      chk("avm_address", 32'(avm_address), 32'(xa));
      chk("avm_writedata", avm_writedata, xwd);
      chk("busy", 32'(busy), 32'(xb));
      chk("done", 32'(done), 32'(xd));
      chk("error", 32'(error), 32'(xe));
      chk("entry_idx", 32'(entry_idx), 32'(xi));
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_start(input int unsigned dly, input int unsigned hang);
    sdly = dly; shang = hang; seq_w0 = tot_w;
    start = 1'b1;
    build_model(cyc + 1, dly, hang);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int unsigned lim);
    bit ok;
    ok = 0;
    for (int unsigned i = 0; i < lim; i++) begin
      tick();
      if (done || error) begin
        ok = 1;
        break;
      end
    end
    chk("sequence_finished", 32'(ok), 32'd1);
  endtask

  task automatic wait_writes(input int unsigned n, input int unsigned lim);
    bit ok;
    ok = 0;
    for (int unsigned i = 0; i < lim; i++) begin
      tick();
      if (tot_w - seq_w0 >= n) begin
        ok = 1;
        break;
      end
    end
    chk("write_count_reached", 32'(ok), 32'd1);
  endtask

  initial begin
    int unsigned s, d, h;
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_select", 32'(avm_select), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Busy clears 40 cycles after each write; stray start during entry 5
    do_start(40, NOHANG);
    s = seq_w0;
    wait_writes(6, 1000);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_end(3000);
    chk("a_writes", tot_w - s, 32'd11);
    chk("a_write_spacing", wcyc[s + 1] - wcyc[s], 32'd49);
    chk("a_first_data", wdat[s], 32'h0000_1E00);
    chk("a_last_data", wdat[s + 10], 32'h0000_1201);
    chk("a_done", 32'(done), 32'd1);
    chk("a_idx", 32'(entry_idx), 32'd10);
    repeat (5) tick();

    // Entry 3 never finishes: timeout
    do_start(40, 3);
    s = seq_w0;
    wait_end(3000);
    chk("b_writes", tot_w - s, 32'd4);
    chk("b_timeout_delay", cyc - wcyc[s + 3], 32'd500);
    chk("b_error", 32'(error), 32'd1);
    chk("b_idx", 32'(entry_idx), 32'd3);
    repeat (30) tick();
    chk("b_no_more_writes", tot_w - s, 32'd4);

    // Restart from ERROR, busy already clear at every poll
    do_start(0, NOHANG);
    s = seq_w0;
    chk("c_error_cleared", 32'(error), 32'd0);
    wait_end(3000);
    chk("c_writes", tot_w - s, 32'd11);
    chk("c_write_spacing", wcyc[s + 1] - wcyc[s], 32'd9);
    chk("c_done", 32'(done), 32'd1);
    repeat (5) tick();

    // Reset in the gap after write 7
    do_start(40, NOHANG);
    s = seq_w0;
    wait_writes(8, 1000);
    rst = 1'b0;
    mbase = cyc + 1; mend = 0; f_done = 0; f_err = 0; f_idx = 0;
    tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("d_no_writes_after_reset", tot_w - s, 32'd8);
    do_start(0, NOHANG);
    s = seq_w0;
    tick();
    chk("d_restart_write", tot_w - s, 32'd1);
    chk("d_restart_data", wdat[s], 32'h0000_1E00);
    wait_end(3000);
    chk("d_done", 32'(done), 32'd1);
    repeat (5) tick();

    // Random slave delays, sometimes with a stuck entry
    for (int it = 0; it < 3; it++) begin
      d = $urandom_range(0, 60);
      h = ($urandom_range(0, 1) == 0) ? NOHANG : $urandom_range(0, 10);
      do_start(d, h);
      wait_end(3000);
      repeat (10) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avm_audio_config_master.md
Name: avm_audio_config_master

Overview:
Avalon-MM master that drives the audio controller's register slave port to bring the WM8731/WM8731L codec up after reset.
It sequences a fixed table of codec register writes. Each write is issued through the controller's I2C command register. After each write, the block polls the controller status register until the I2C transfer completes, then moves to the next entry.
It sits between system control (start/done/error) and the audio controller's Avalon-MM slave, so no CPU is needed for codec bring-up.

Parameters:
SYSCLK, 50, system clock in MHz; used only for the TIMEOUT_CYC default.
I2C_ADDR, 5'h00, controller register that accepts the I2C command word.
STATUS_ADDR, 5'h1F, controller status register.
BUSY_BIT, 0, bit index of the I2C busy flag in the status word.
RD_LATENCY, 1, cycles from the read strobe to valid avm_readdata; must be at least 1.
POLL_GAP, 16, idle cycles before each status read.
TIMEOUT_CYC, SYSCLK*1000, maximum cycles from a write strobe to seeing busy cleared.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous active-low reset.
start  input  1  begin the sequence; sampled only in IDLE, DONE or ERROR.
busy  output  1  high while a sequence runs.
done  output  1  level; sequence finished OK; cleared by start or reset.
error  output  1  level; timeout occurred; cleared by start or reset.
entry_idx  output  4  index of the current or last-processed table entry.
avm_address  output  5  Avalon address.
avm_select  output  1  Avalon chipselect.
avm_read  output  1  read strobe.
avm_write  output  1  write strobe.
avm_writedata  output  32  write data.
avm_readdata  input  32  read data, valid RD_LATENCY cycles after avm_read.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - busy, done, error, entry_idx, all avm_* outputs, and all counters go to 0.
  - Reset mid-sequence aborts at once; no further bus cycles are issued, and any outstanding read data is ignored.
- Table: 11 entries, index 0..10. Each command word is {16'h0, reg[6:0], data[8:0]}. Values in order:
  - 0x1E00, 0x0017, 0x0217, 0x0479, 0x0679, 0x0812
  - 0x0A00, 0x0C00, 0x0E02, 0x1000, 0x1201
  - Meaning: reset, line-in L/R, headphone L/R, analog path, digital path, power-down, I2S 16-bit, 48 kHz normal mode, active.
- IDLE / DONE / ERROR on start==1:
  - Clear done and error; set entry_idx=0 and busy=1.
  - Go to WRITE on the next cycle.
- WRITE (one cycle):
  - avm_select=1, avm_write=1, avm_address=I2C_ADDR, avm_writedata=table[entry_idx].
  - Clear the timeout counter; go to GAP.
- GAP:
  - Count POLL_GAP cycles with all strobes 0, then go to RD.
- RD (one cycle):
  - avm_select=1, avm_read=1, avm_address=STATUS_ADDR; go to RDWAIT.
- RDWAIT:
  - Wait RD_LATENCY cycles, then sample avm_readdata[BUSY_BIT].
  - Busy bit == 0 with entry_idx<10: entry_idx+1, go to WRITE.
  - Busy bit == 0 with entry_idx==10: go to DONE; done=1, busy=0.
  - Busy bit == 1: go to GAP.
- Timeout:
  - The timeout counter increments every cycle from the cycle after WRITE.
  - When it reaches TIMEOUT_CYC in GAP, RD or RDWAIT, go to ERROR; error=1, busy=0.
  - entry_idx holds the failing index.
  - A busy==0 sample in the same cycle as the timeout wins, i.e. the block advances.
- Strobes:
  - avm_read and avm_write are never high together, and each is exactly one cycle wide.
  - avm_select is high only in strobe cycles; address and writedata are 0 otherwise.
- start while busy==1 is ignored. done and error are never both high.
- Total sequence length is at least 11*(POLL_GAP+RD_LATENCY+2) cycles.

Test Plan:
- Reset, then start with a slave model whose busy clears after 40 cycles per write:
  - 11 writes occur at I2C_ADDR with data 0x1E00..0x1201 in table order.
  - done=1, busy=0, entry_idx=10, error=0.
- Slave busy never clears on entry 3, with TIMEOUT_CYC set to 500:
  - Exactly 4 writes occur.
  - error=1 exactly 500 cycles after the 4th write strobe; entry_idx=3; no further strobes.
- Slave busy already 0 on the first poll, RD_LATENCY=3:
  - Each status read is sampled exactly 3 cycles after avm_read.
  - The next write follows 1 cycle after that sample.
- Assert start during entry 5:
  - Ignored; the sequence continues and the write count stays 11.
- Drive rst=0 in the GAP state of entry 7:
  - All outputs are 0 on the next cycle and no strobes follow.
  - A new start restarts from entry 0 with write data 0x1E00.
- Start from ERROR:
  - error clears the cycle after start.
  - A full successful sequence then completes with done=1.
